mor1kx_sysspr_access: RTL and testbench
=======================================

Name: mor1kx_sysspr_access

Overview:
- SPR-bus responder for system group 0 (addresses 0x0000–0x000F).
- Serves mfspr reads of the read-only configuration words (VR, UPR, CPUCFGR, MMU/cache cfg, DCFGR, PCCFGR, VR2, AVR), which arrive as input ports from the configuration-register block.
- Owns the writable group-0 registers EVBAR, AECR and AESR.
- Sits between the ctrl stage's SPR bus and the cfg-register outputs, and drives the exception-vector base and arithmetic-exception controls to the pipeline.

Parameters:
- FEATURE_EVBAR, "NONE": "ENABLED" implements EVBAR; otherwise it reads 0 and ignores writes.
- FEATURE_AECSR, "NONE": "ENABLED" implements AECR/AESR; otherwise both read 0, ignore writes and never set.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- spr_bus_stb_i  in  1  access strobe; held until ack.
- spr_bus_we_i  in  1  1 = write (mtspr), 0 = read (mfspr).
- spr_bus_addr_i  in  16  SPR address; [15:11] = group, [10:0] = index.
- spr_bus_dat_i  in  32  write data.
- spr_bus_ack_o  out  1  one-cycle access acknowledge.
- spr_bus_dat_o  out  32  read data, valid with ack.
- supervisor_mode_i  in  1  SR[SM]; writes are performed only when 1.
- spr_vr_i, spr_vr2_i, spr_upr_i, spr_cpucfgr_i, spr_dmmucfgr_i, spr_immucfgr_i, spr_dccfgr_i, spr_iccfgr_i, spr_dcfgr_i, spr_pccfgr_i, spr_avr_i  in  32 each  read-only configuration words.
- aesr_set_i  in  7  per-bit sticky set pulses from the ALU/MAC arithmetic-exception detection.
- spr_evbar_o  out  32  exception vector base; bits [12:0] are always 0.
- spr_aecr_o  out  7  arithmetic exception enable bits.
- spr_aesr_o  out  7  arithmetic exception status bits.

Behaviour:
- Reset (async, rst=1):
  - spr_bus_ack_o=0, spr_bus_dat_o=0.
  - EVBAR=0, AECR=0, AESR=0.
  - FSM goes to IDLE.
- FSM:
  - IDLE: if stb=1 and addr[15:11]==0, latch we/addr/dat, go to ACK.
  - IDLE, other group: stay in IDLE, no ack (another unit owns that access).
  - ACK: ack_o=1 for exactly this cycle, dat_o valid; go to IDLE unconditionally.
  - stb is not sampled in ACK, so a held stb cannot be double-counted.
  - Minimum access period is 2 cycles; latency is stb-sample edge to ack = 1 cycle.
- Read decode by index [10:0]:
  - 0 VR, 1 UPR, 2 CPUCFGR, 3 DMMUCFGR, 4 IMMUCFGR, 5 DCCFGR, 6 ICCFGR, 7 DCFGR, 8 PCCFGR, 9 VR2, 10 AVR.
  - 11 EVBAR, 12 AECR (zero-extended), 13 AESR (zero-extended).
  - Any other index reads 0 and is still acked.
  - Read data is the register value at the sample edge; it is registered into dat_o.
- Write, performed at the IDLE→ACK edge and only when supervisor_mode_i=1:
  - Index 11: EVBAR <= {dat_i[31:13], 13'b0}.
  - Index 12: AECR <= dat_i[6:0].
  - Index 13: AESR <= dat_i[6:0].
  - All other indices are ignored.
- User-mode write (supervisor_mode_i=0): still acked, no state change. dat_o=0 on writes.
- AESR sticky update each cycle: AESR <= (write ? dat_i[6:0] : AESR) | aesr_set_i.
  - Same-cycle write and set: set bits win, so a write of 0 while bit3 is set yields bit3=1.
- Disabled features: the affected registers are held at 0 and aesr_set_i is ignored.
- Reset asserted while in ACK: ack drops immediately (async), and a latched write not yet performed is lost.
- Outputs spr_evbar_o, spr_aecr_o and spr_aesr_o are direct register outputs, so a write is visible the cycle after its sample edge.

Test Plan:
1. Read of index 2 with spr_cpucfgr_i=0x0000_0720 → ack exactly 1 cycle after the stb sample; dat_o=0x0000_0720; ack low on the following cycle even with stb still high.
2. FEATURE_EVBAR="ENABLED", supervisor write 0xFFFF_FFFF to index 11 → spr_evbar_o=0xFFFF_E000; readback of index 11 returns 0xFFFF_E000.
3. supervisor_mode_i=0, write 0x7F to index 12 → acked; spr_aecr_o stays 0x00.
4. aesr_set_i=0x08 for 1 cycle → spr_aesr_o=0x08 and stays there; write 0 to index 13 in the same cycle as aesr_set_i=0x08 → AESR=0x08; write 0 with no set → 0x00.
5. Access with addr=0x0800 (group 1), stb held 5 cycles → no ack and no state change. Read of index 0x7FF in group 0 → ack with dat_o=0.
6. Assert rst during the ACK cycle of an EVBAR write → ack deasserts immediately, EVBAR=0 after reset, and the FSM accepts a new read in the first cycle after reset release.

Source files
------------

// File: rtl/mor1kx_sysspr_access.sv
// SPR group-0 responder: serves read-only config words and owns EVBAR/AECR/AESR.
// One access per two cycles; ack one cycle after the strobe is sampled, no wait states.
module mor1kx_sysspr_access #(
  parameter string FEATURE_EVBAR = "NONE",
  parameter string FEATURE_AECSR = "NONE"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spr_bus_stb_i,
  input  logic        spr_bus_we_i,
  input  logic [15:0] spr_bus_addr_i,
  input  logic [31:0] spr_bus_dat_i,
  output logic        spr_bus_ack_o,
  output logic [31:0] spr_bus_dat_o,
  input  logic        supervisor_mode_i,
  input  logic [31:0] spr_vr_i,
  input  logic [31:0] spr_vr2_i,
  input  logic [31:0] spr_upr_i,
  input  logic [31:0] spr_cpucfgr_i,
  input  logic [31:0] spr_dmmucfgr_i,
  input  logic [31:0] spr_immucfgr_i,
  input  logic [31:0] spr_dccfgr_i,
  input  logic [31:0] spr_iccfgr_i,
  input  logic [31:0] spr_dcfgr_i,
  input  logic [31:0] spr_pccfgr_i,
  input  logic [31:0] spr_avr_i,
  input  logic [6:0]  aesr_set_i,
  output logic [31:0] spr_evbar_o,
  output logic [6:0]  spr_aecr_o,
  output logic [6:0]  spr_aesr_o
);

  localparam bit EVBAR_EN = (FEATURE_EVBAR == "ENABLED");
  localparam bit AECSR_EN = (FEATURE_AECSR == "ENABLED");

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        wr_en;
  logic [10:0] idx;
  logic [31:0] rd_dat;
  logic [31:0] evbar;
  logic [6:0]  aecr;
  logic [6:0]  aesr;
  logic        unused_ok;

  assign idx       = spr_bus_addr_i[10:0];
  assign accept    = (state == IDLE) && spr_bus_stb_i && (spr_bus_addr_i[15:11] == 5'd0);
  assign wr_en     = accept && spr_bus_we_i && supervisor_mode_i;
  assign unused_ok = ^spr_bus_dat_i[12:7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The strobe is deliberately ignored in ACK so a held strobe is not counted twice.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spr_bus_ack_o = (state == ACK);
  end

  always_comb begin
    rd_dat = 32'd0;
    case (idx)
      11'd0:   rd_dat = spr_vr_i;
      11'd1:   rd_dat = spr_upr_i;
      11'd2:   rd_dat = spr_cpucfgr_i;
      11'd3:   rd_dat = spr_dmmucfgr_i;
      11'd4:   rd_dat = spr_immucfgr_i;
      11'd5:   rd_dat = spr_dccfgr_i;
      11'd6:   rd_dat = spr_iccfgr_i;
      11'd7:   rd_dat = spr_dcfgr_i;
      11'd8:   rd_dat = spr_pccfgr_i;
      11'd9:   rd_dat = spr_vr2_i;
      11'd10:  rd_dat = spr_avr_i;
      11'd11:  rd_dat = evbar;
      11'd12:  rd_dat = {25'd0, aecr};
      11'd13:  rd_dat = {25'd0, aesr};
      default: rd_dat = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         spr_bus_dat_o <= 32'd0;
    else if (accept && !spr_bus_we_i) spr_bus_dat_o <= rd_dat;
    else                             spr_bus_dat_o <= 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       evbar <= 32'd0;
    else if (!EVBAR_EN)            evbar <= 32'd0;
    else if (wr_en && idx == 11'd11) evbar <= {spr_bus_dat_i[31:13], 13'd0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       aecr <= 7'd0;
    else if (!AECSR_EN)            aecr <= 7'd0;
    else if (wr_en && idx == 11'd12) aecr <= spr_bus_dat_i[6:0];
  end

  // Set pulses are ORed after the write so a detected exception is never lost to a clearing write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            aesr <= 7'd0;
    else if (!AECSR_EN) aesr <= 7'd0;
    else                aesr <= ((wr_en && idx == 11'd13) ? spr_bus_dat_i[6:0] : aesr) | aesr_set_i;
  end

  assign spr_evbar_o = evbar;
  assign spr_aecr_o  = aecr;
  assign spr_aesr_o  = aesr;

endmodule

// File: tb/tb_mor1kx_sysspr_access.sv
// Randomized scoreboard bench for the group-0 SPR responder with both features enabled.
module tb_mor1kx_sysspr_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        smode;
  logic [31:0] cfg_w [0:10];
  logic [6:0]  aset;
  logic [31:0] evbar;
  logic [6:0]  aecr;
  logic [6:0]  aesr;

  int checks = 0;
  int failures = 0;

  logic [31:0] expq [$];
  logic [31:0] m_ev;
  logic [6:0]  m_aecr;
  logic [6:0]  m_aesr;

  always #5 clk = ~clk;

  mor1kx_sysspr_access #(
    .FEATURE_EVBAR("ENABLED"),
    .FEATURE_AECSR("ENABLED")
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .spr_bus_stb_i    (stb),
    .spr_bus_we_i     (we),
    .spr_bus_addr_i   (addr),
    .spr_bus_dat_i    (wdat),
    .spr_bus_ack_o    (ack),
    .spr_bus_dat_o    (rdat),
    .supervisor_mode_i(smode),
    .spr_vr_i         (cfg_w[0]),
    .spr_vr2_i        (cfg_w[9]),
    .spr_upr_i        (cfg_w[1]),
    .spr_cpucfgr_i    (cfg_w[2]),
    .spr_dmmucfgr_i   (cfg_w[3]),
    .spr_immucfgr_i   (cfg_w[4]),
    .spr_dccfgr_i     (cfg_w[5]),
    .spr_iccfgr_i     (cfg_w[6]),
    .spr_dcfgr_i      (cfg_w[7]),
    .spr_pccfgr_i     (cfg_w[8]),
    .spr_avr_i        (cfg_w[10]),
    .aesr_set_i       (aset),
    .spr_evbar_o      (evbar),
    .spr_aecr_o       (aecr),
    .spr_aesr_o       (aesr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference view of the register file: what an mfspr of each index should return.
  function automatic logic [31:0] mread(input logic [10:0] idx);
    if (idx <= 11'd10) return cfg_w[idx];
    if (idx == 11'd11) return m_ev;
    if (idx == 11'd12) return {25'd0, m_aecr};
    if (idx == 11'd13) return {25'd0, m_aesr};
    return 32'd0;
  endfunction

  function automatic void mwrite(input logic [10:0] idx, input logic [31:0] d);
    if (idx == 11'd11) m_ev = d & 32'hFFFF_E000;
    if (idx == 11'd12) m_aecr = d[6:0];
    if (idx == 11'd13) m_aesr = d[6:0];
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, "_evbar"}, evbar, m_ev);
    chk({tag, "_aecr"}, {25'd0, aecr}, {25'd0, m_aecr});
    chk({tag, "_aesr"}, {25'd0, aesr}, {25'd0, m_aesr});
  endtask

  // Monitor: every ack consumes one expected read-data word.
  always @(negedge clk) begin
    if (!rst && ack) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_ack actual=1 expected=0 dat=%h @%0t", rdat, $time);
      end else begin
        chk("ack_dat", rdat, expq.pop_front());
      end
    end
  end

  task automatic access(input bit w, input logic [4:0] grp, input logic [10:0] idx,
                        input logic [31:0] d, input bit sm, input logic [6:0] set);
    @(negedge clk);
    stb = 1'b1; we = w; addr = {grp, idx}; wdat = d; smode = sm; aset = set;
    if (grp == 5'd0) begin
      expq.push_back(w ? 32'd0 : mread(idx));
      @(posedge clk);
      if (w && sm) mwrite(idx, d);
      m_aesr = m_aesr | set;
      @(negedge clk);
      chk("ack_latency", {31'd0, ack}, 32'd1);
      aset = 7'd0;
      @(posedge clk);
      @(negedge clk);
      chk("ack_single", {31'd0, ack}, 32'd0);
      stb = 1'b0;
    end else begin
      repeat (5) begin
        @(posedge clk);
        m_aesr = m_aesr | aset;
        @(negedge clk);
        chk("foreign_noack", {31'd0, ack}, 32'd0);
        aset = 7'd0;
      end
      stb = 1'b0;
    end
    check_regs("post_access");
  endtask

  task automatic idle(input logic [6:0] set);
    @(negedge clk);
    stb = 1'b0; aset = set;
    @(posedge clk);
    m_aesr = m_aesr | set;
    @(negedge clk);
    aset = 7'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 16'd0; wdat = 32'd0; smode = 1'b0; aset = 7'd0;
    for (int i = 0; i <= 10; i++) cfg_w[i] = $urandom;
    cfg_w[2] = 32'h0000_0720;
    m_ev = 32'd0; m_aecr = 7'd0; m_aesr = 7'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    check_regs("rst");
    rst = 1'b0;

    access(1'b0, 5'd0, 11'd2, 32'd0, 1'b1, 7'd0);
    access(1'b1, 5'd0, 11'd11, 32'hFFFF_FFFF, 1'b1, 7'd0);
    chk("evbar_all_ones", evbar, 32'hFFFF_E000);
    access(1'b0, 5'd0, 11'd11, 32'd0, 1'b1, 7'd0);
    access(1'b1, 5'd0, 11'd12, 32'h7F, 1'b0, 7'd0);
    chk("user_aecr", {25'd0, aecr}, 32'd0);

    idle(7'h08);
    chk("aesr_set", {25'd0, aesr}, 32'h08);
    idle(7'h00);
    idle(7'h00);
    chk("aesr_sticky", {25'd0, aesr}, 32'h08);
    access(1'b1, 5'd0, 11'd13, 32'd0, 1'b1, 7'h08);
    chk("aesr_set_wins", {25'd0, aesr}, 32'h08);
    access(1'b1, 5'd0, 11'd13, 32'd0, 1'b1, 7'h00);
    chk("aesr_clear", {25'd0, aesr}, 32'h00);

    access(1'b1, 5'd1, 11'd11, 32'h1234_5678, 1'b1, 7'd0);
    access(1'b0, 5'd0, 11'h7FF, 32'd0, 1'b1, 7'd0);

    // Reset in the middle of the ACK cycle of an EVBAR write.
    @(negedge clk);
    stb = 1'b1; we = 1'b1; addr = 16'd11; wdat = 32'hABCD_E000; smode = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_ack_drop", {31'd0, ack}, 32'd0);
    stb = 1'b0; we = 1'b0;
    m_ev = 32'd0; m_aecr = 7'd0; m_aesr = 7'd0;
    @(negedge clk);
    check_regs("mid_rst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    access(1'b0, 5'd0, 11'd11, 32'd0, 1'b1, 7'd0);

    for (int n = 0; n < 300; n++) begin
      logic [4:0]  grp;
      logic [10:0] idx;
      logic [6:0]  set;
      set = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
      if ($urandom_range(0, 9) < 2) begin
        idle(set);
      end else begin
        grp = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        idx = ($urandom_range(0, 9) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
        access($urandom_range(0, 1) == 1, grp, idx, $urandom, $urandom_range(0, 3) != 0, set);
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
